// File: rtl/lock_pkg.sv
// Shared display definitions: digit record, segment constants and hex-to-segment table.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package lock_pkg;

  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, value: 4'h0};

endpackage

// File: rtl/seg_scan_display_if.sv
// Command bus into the scanned display: digit writes, password shifts, clear and masking.
// Every strobe (clr, wr_en, shift_en) is a single-cycle command sampled on each rising clk
// edge; there is no ready, the display accepts one command per cycle unconditionally.
interface seg_scan_display_if;
  logic       clr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_blank;
  logic       shift_en;
  logic [3:0] shift_data;
  logic       mask_dot;

  modport master (
    output clr, wr_en, wr_addr, wr_data, wr_blank, shift_en, shift_data, mask_dot
  );

  modport slave (
    input clr, wr_en, wr_addr, wr_data, wr_blank, shift_en, shift_data, mask_dot
  );
endinterface

// File: rtl/seg_scan_display_hex_decode.sv
// Combinational digit decoder: blank wins over masking, masking wins over the hex value.
module seg_hex_decode
  import lock_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       mask_dot,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[value];
    if (blank) begin
      seg = SEG_BLANK;
    end else if (mask_dot) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Registered 8-digit hex buffer time-multiplexed onto a common 7-segment display.
// Optional SEG_SCAN_BLINK_EN adds blink_mask and a slow blink phase for flagged digits.
module seg_scan_display
  import lock_pkg::*;
#(
  parameter int CNT_THRESHOLD = 1000000 - 1,
  parameter int DIGITS        = 8
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_display_if.slave   bus,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [7:0]          blink_mask,
`endif
  output logic [7:0]          led_en,
  output logic [6:0]          led
);

  localparam int DW = (CNT_THRESHOLD > 0) ? $clog2(CNT_THRESHOLD + 1) : 1;

  logic [DW-1:0] div_q;
  logic          wrap;
  logic [2:0]    idx_q;
  digit_t        buf_q [8];
  digit_t        cur;
  logic [6:0]    seg_raw;
  logic [6:0]    seg_next;

  assign wrap = (div_q == DW'(CNT_THRESHOLD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (wrap) begin
      div_q <= '0;
      idx_q <= (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Only lanes below DIGITS are ever updated; higher lanes stay at their reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= DIGIT_RESET;
    end else if (bus.clr) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= DIGIT_RESET;
    end else if (bus.wr_en) begin
      if (int'(bus.wr_addr) < DIGITS) begin
        buf_q[bus.wr_addr] <= '{blank: bus.wr_blank, value: bus.wr_data};
      end
    end else if (bus.shift_en) begin
      for (int i = 1; i < DIGITS; i++) buf_q[i] <= buf_q[i-1];
      buf_q[0] <= '{blank: 1'b0, value: bus.shift_data};
    end
  end

  assign cur = buf_q[idx_q];

  seg_hex_decode u_decode (
    .value    (cur.value),
    .blank    (cur.blank),
    .mask_dot (bus.mask_dot),
    .seg      (seg_raw)
  );

`ifdef SEG_SCAN_BLINK_EN
  logic [7:0] blink_cnt_q;
  logic       blink_off_q;

  // Phase flips once per 256 divider wraps; starts in the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (wrap) begin
      blink_cnt_q <= blink_cnt_q + 8'd1;
      if (blink_cnt_q == 8'hFF) blink_off_q <= ~blink_off_q;
    end
  end

  assign seg_next = (blink_off_q && blink_mask[idx_q]) ? SEG_BLANK : seg_raw;
`else
  assign seg_next = seg_raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_en <= 8'hFF;
      led    <= SEG_BLANK;
    end else begin
      led_en <= ~(8'b1 << idx_q);
      led    <= seg_next;
    end
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the lock state machine's display data.
- Holds an 8-digit hex display buffer, written by address or shifted in as keys are typed.
- Time-multiplexes the buffer onto the board's 8-digit common 7-segment display (led_en/led).
- Replaces ad-hoc segment logic inside the state machine with a reusable, registered display stage.

Parameters:
- CNT_THRESHOLD, 1000000-1: refresh divider terminal count; the scan advances one digit every CNT_THRESHOLD+1 clk cycles.
- DIGITS, 8: number of digit positions (2..8); indices at or above DIGITS are never enabled.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- clr  input  1  synchronous: blank all digits and zero the buffer.
- wr_en  input  1  write one digit this cycle.
- wr_addr  input  3  digit index to write; 0 = rightmost.
- wr_data  input  4  hex value to write.
- wr_blank  input  1  with wr_en: mark the digit blank instead of showing wr_data.
- shift_en  input  1  shift the buffer left one digit and insert shift_data at index 0 (password entry).
- shift_data  input  4  value inserted by shift_en.
- mask_dot  input  1  when 1, non-blank digits show "-" instead of their value (password hiding).
- led_en  output  8  digit enables, active-low, one-hot-zero while scanning.
- led  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - buffer = 0, all digits blank, scan index = 0, divider = 0.
  - led_en = 8'hFF, led = 7'h7F.
- Divider:
  - Counts 0..CNT_THRESHOLD, then wraps to 0.
  - On wrap, the scan index increments modulo DIGITS (7 -> 0 for DIGITS=8).
- Buffer update, one per cycle, priority clr > wr_en > shift_en:
  - clr: every digit set to value 0, blank.
  - wr_en: buffer[wr_addr] = wr_data, blank = wr_blank. Ignored if wr_addr >= DIGITS.
  - shift_en: digit i takes digit i-1 for i = DIGITS-1 down to 1; the top digit is discarded; digit 0 = shift_data, non-blank.
  - Simultaneous wr_en and shift_en: only the write takes effect; the shift is dropped.
- Output stage (registered; one cycle of latency from the scan index and buffer to the pins):
  - led_en = ~(1 << index).
  - Blank digit: led = 7'h7F while its enable is still driven.
  - mask_dot=1 on a non-blank digit: led = 7'h3F ("-", g segment only).
  - Otherwise: led = hex decode of the digit value:
    - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
    - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- A buffer change becomes visible the next time its digit is scanned, with one cycle of register latency; there is no tearing within a digit slot.
- Reset mid-scan: outputs go to their reset values immediately (asynchronously); scanning restarts at index 0 after release.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask[7:0] and an internal blink counter toggling every 256 divider wraps.
  - During the off phase, digits with blink_mask[i]=1 output led = 7'h7F; led_en is unchanged.
  - Used to flag a wrong password.
- Not defined:
  - No blink_mask port and no blink counter.
  - Display is always steady.

Decomposition:
- Shared package lock_pkg:
  - SEG_BLANK (7'h7F), SEG_DASH (7'h3F).
  - The 16-entry hex-to-segment constant table.
  - A digit_t typedef {blank, value[3:0]}.
- One natural sub-module: seg_hex_decode, purely combinational; 4-bit value plus mask_dot/blank in, 7 segment bits out.
- Divider, scan index, buffer and output registers stay in seg_scan_display.

Test Plan:
- Reset, CNT_THRESHOLD=3: hold rst=0 -> led_en=FF, led=7F; release -> index advances every 4 clk; led_en steps FE, FD, ... 7F, FE; every led=7F (all digits blank).
- Write at addr 0 (wr_data=4'h5, wr_blank=0) -> in slot led_en=FE, led=12. Write at addr 7 (4'hA) -> slot 7F shows 08. Write wr_addr=3'b111 with DIGITS=6 -> ignored, buffer unchanged.
- Shift 1, 2, 3 -> digits 0..2 read 3, 2, 1 (led 30, 24, 79). After 8 more shifts the original "1" is discarded from the top.
- Same cycle wr_en (addr 2, 4'hF) and shift_en -> digit 2 = F (0E); no shift occurs. Same cycle clr and wr_en -> all blank.
- mask_dot=1 with digits 0..3 loaded -> those slots show 3F; blank slots stay 7F.
- Assert rst mid-slot -> led_en=FF on the same edge, without waiting for clk. With SEG_SCAN_BLINK_EN and blink_mask=01 -> digit 0 alternates between its value and 7F every 256 wraps.
